ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Consumes completed scan-code events from the PS/2 receiver (16-bit rec_data, 1-cycle rec_flag pulse). Tracks modifier state (Shift, Ctrl, Caps Lock), translates Set-2 US make codes to ASCII, and buffers characters in a small FIFO. Application logic (UART, LCD, CPU) pops characters through a valid/ready handshake.

Parameters:
FIFO_DEPTH, 8, number of character entries; must be a power of 2, minimum 2.
ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
sys_clk  in  1  system clock, sole clock domain.
sys_rst  in  1  asynchronous active-high reset.
rec_data  in  16  receiver event: bit12 = extended (E0) flag, bit8 = break (F0) flag, [7:0] = scan code; other bits ignored.
rec_flag  in  1  one-cycle strobe; rec_data is valid in the same cycle.
key_ready  in  1  consumer accepts the head character.
key_valid  out  1  FIFO is non-empty.
key_ascii  out  8  head character (show-ahead); 0x00 when empty.
shift_o  out  1  left or right Shift is held.
ctrl_o  out  1  left or right Ctrl is held.
caps_o  out  1  Caps Lock toggle state.
overflow  out  1  sticky: a character was dropped because the FIFO was full.
overflow_clr  in  1  clears overflow.
fifo_count  out  ADDR_W+1  current occupancy.

Behaviour:
- Reset: one clock, sys_clk; reset is asynchronous and active-high (sys_rst). All outputs and all state go to 0, including held-key flags, caps_o, FIFO pointers and overflow. Reset asserted mid-operation discards FIFO contents and all modifier state.
- Event stage: on a sys_clk edge with rec_flag=1, the event is decoded and registered. Modifiers update on that edge. A translatable key produces push=1 and a char register for one cycle.
- Latency: rec_flag high at edge E0 -> push at edge E1 -> key_valid=1 and key_ascii valid after E1 (FIFO was empty). Total 2 cycles.
- Modifier codes (never pushed):
  - 0x12 (L-Shift) and 0x59 (R-Shift): make sets, break clears.
  - 0x14 (Ctrl, with or without E0): make sets, break clears. Left and right Ctrl are tracked separately; ctrl_o is their OR.
  - 0x58 (Caps): make toggles caps_o only when caps_held=0, then sets caps_held. Break clears caps_held. Typematic repeats therefore do not re-toggle.
- Translation uses modifier state from before the event.
- Breaks: break events of non-modifier keys are ignored.
- Extended keys: only E0 5A maps to 0x0D and E0 4A maps to 0x2F. Every other extended key is ignored.
- Letters (code -> letter): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Uppercase if shift XOR caps, otherwise lowercase.
  - If ctrl_o=1, output is (uppercase & 0x1F); Ctrl overrides case.
- Digits (code -> digit): 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - Unshifted: ASCII digit.
  - Shifted: ) ! @ # $ % ^ & * ( respectively.
  - Caps Lock and Ctrl have no effect on digits.
- Controls: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 76 -> 0x1B, 0D -> 0x09.
- All other codes: no push, no error.
- FIFO:
  - pop = key_valid & key_ready.
  - Push when full and no pop: character dropped, overflow set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when count=1: head advances to the new character.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow_clr clears overflow. If a drop occurs in the same cycle, set wins.
- Consumer rule: key_ascii holds stable while key_valid=1 and key_ready=0.

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants (SC_LSHIFT 8'h12, SC_RSHIFT 8'h59, SC_CTRL 8'h14, SC_CAPS 8'h58, SC_ENTER 8'h5A, SC_KP_SLASH 8'h4A);
  - rec_data field bit positions (EXT_BIT 12, BRK_BIT 8);
  - ASCII constants for CR, BS, ESC, TAB.
- Combinational sub-module ps2_scan2ascii: inputs code, ext, shift, caps, ctrl; outputs ascii[7:0] and hit.
- The top level holds modifier registers, the event stage and the FIFO (inline, about 60 lines).

Test Plan:
- Strobe 0x001C -> after 2 cycles key_valid=1, key_ascii=0x61 ('a'). Assert key_ready 1 cycle -> key_valid=0, fifo_count=0.
- Events 0x0012, 0x001C, 0x0112, 0x001C -> FIFO yields 0x41 then 0x61; shift_o high between the two Shift events.
- Events 0x0058 make three times (typematic), 0x0158, then 0x0032 -> caps_o=1, output 0x42. Add Shift + 0x0032 -> 0x62.
- Events 0x1014, 0x0021, 0x1114, then 0x1071 (unmapped extended) -> output 0x03 only; ctrl_o returns to 0.
- Hold key_ready=0 and push 9 'a' events with FIFO_DEPTH=8 -> fifo_count=8, overflow=1. Then pop+push in the same cycle when full -> count stays 8, no extra drop. Pulse overflow_clr -> overflow=0.
- Assert sys_rst asynchronously with 3 entries queued and Shift held -> immediately key_valid=0, shift_o=0, caps_o=0, fifo_count=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder: scan codes, event fields, ASCII codes.
package ps2_pkg;

   localparam int unsigned SCAN_W  = 8;
   localparam int unsigned REC_W   = 16;
   localparam int unsigned ASCII_W = 8;

   // rec_data field positions
   localparam int unsigned EXT_BIT = 12;
   localparam int unsigned BRK_BIT = 8;

   // Set-2 scan codes with special handling
   localparam logic [SCAN_W-1:0] SC_LSHIFT   = 8'h12;
   localparam logic [SCAN_W-1:0] SC_RSHIFT   = 8'h59;
   localparam logic [SCAN_W-1:0] SC_CTRL     = 8'h14;
   localparam logic [SCAN_W-1:0] SC_CAPS     = 8'h58;
   localparam logic [SCAN_W-1:0] SC_ENTER    = 8'h5A;
   localparam logic [SCAN_W-1:0] SC_KP_SLASH = 8'h4A;
   localparam logic [SCAN_W-1:0] SC_SPACE    = 8'h29;
   localparam logic [SCAN_W-1:0] SC_BKSP     = 8'h66;
   localparam logic [SCAN_W-1:0] SC_ESC      = 8'h76;
   localparam logic [SCAN_W-1:0] SC_TAB      = 8'h0D;

   // ASCII codes for the non-printing keys
   localparam logic [ASCII_W-1:0] ASCII_CR    = 8'h0D;
   localparam logic [ASCII_W-1:0] ASCII_BS    = 8'h08;
   localparam logic [ASCII_W-1:0] ASCII_ESC   = 8'h1B;
   localparam logic [ASCII_W-1:0] ASCII_TAB   = 8'h09;
   localparam logic [ASCII_W-1:0] ASCII_SPACE = 8'h20;
   localparam logic [ASCII_W-1:0] ASCII_SLASH = 8'h2F;

   // Decoded receiver event
   typedef struct packed {
      logic              ext;
      logic              brk;
      logic [SCAN_W-1:0] code;
   } scan_evt_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational Set-2 (US layout) scan code to ASCII translation.
module ps2_scan2ascii
   import ps2_pkg::*;
(
   input  logic [SCAN_W-1:0]  code,
   input  logic               ext,
   input  logic               shift,
   input  logic               caps,
   input  logic               ctrl,
   output logic [ASCII_W-1:0] ascii,
   output logic               hit
);

   logic [ASCII_W-1:0] upper;
   logic [ASCII_W-1:0] dig_plain;
   logic [ASCII_W-1:0] dig_shift;
   logic [ASCII_W-1:0] ctl_ch;
   logic               is_letter;
   logic               is_digit;
   logic               is_ctl;

   // Letter keys: uppercase character for each code
   always_comb begin
      upper     = '0;
      is_letter = 1'b1;
      case (code)
         8'h1C: upper = 8'h41;
         8'h32: upper = 8'h42;
         8'h21: upper = 8'h43;
         8'h23: upper = 8'h44;
         8'h24: upper = 8'h45;
         8'h2B: upper = 8'h46;
         8'h34: upper = 8'h47;
         8'h33: upper = 8'h48;
         8'h43: upper = 8'h49;
         8'h3B: upper = 8'h4A;
         8'h42: upper = 8'h4B;
         8'h4B: upper = 8'h4C;
         8'h3A: upper = 8'h4D;
         8'h31: upper = 8'h4E;
         8'h44: upper = 8'h4F;
         8'h4D: upper = 8'h50;
         8'h15: upper = 8'h51;
         8'h2D: upper = 8'h52;
         8'h1B: upper = 8'h53;
         8'h2C: upper = 8'h54;
         8'h3C: upper = 8'h55;
         8'h2A: upper = 8'h56;
         8'h1D: upper = 8'h57;
         8'h22: upper = 8'h58;
         8'h35: upper = 8'h59;
         8'h1A: upper = 8'h5A;
         default: is_letter = 1'b0;
      endcase
   end

   // Digit row: plain digit and its shifted symbol
   always_comb begin
      dig_plain = '0;
      dig_shift = '0;
      is_digit  = 1'b1;
      case (code)
         8'h45: begin dig_plain = 8'h30; dig_shift = 8'h29; end
         8'h16: begin dig_plain = 8'h31; dig_shift = 8'h21; end
         8'h1E: begin dig_plain = 8'h32; dig_shift = 8'h40; end
         8'h26: begin dig_plain = 8'h33; dig_shift = 8'h23; end
         8'h25: begin dig_plain = 8'h34; dig_shift = 8'h24; end
         8'h2E: begin dig_plain = 8'h35; dig_shift = 8'h25; end
         8'h36: begin dig_plain = 8'h36; dig_shift = 8'h5E; end
         8'h3D: begin dig_plain = 8'h37; dig_shift = 8'h26; end
         8'h3E: begin dig_plain = 8'h38; dig_shift = 8'h2A; end
         8'h46: begin dig_plain = 8'h39; dig_shift = 8'h28; end
         default: is_digit = 1'b0;
      endcase
   end

   // Control keys; only keypad Enter and keypad slash survive from the E0 set
   always_comb begin
      ctl_ch = '0;
      is_ctl = 1'b1;
      if (ext) begin
         case (code)
            SC_ENTER:    ctl_ch = ASCII_CR;
            SC_KP_SLASH: ctl_ch = ASCII_SLASH;
            default:     is_ctl = 1'b0;
         endcase
      end else begin
         case (code)
            SC_SPACE: ctl_ch = ASCII_SPACE;
            SC_ENTER: ctl_ch = ASCII_CR;
            SC_BKSP:  ctl_ch = ASCII_BS;
            SC_ESC:   ctl_ch = ASCII_ESC;
            SC_TAB:   ctl_ch = ASCII_TAB;
            default:  is_ctl = 1'b0;
         endcase
      end
   end

   // Apply modifiers: Ctrl beats case on letters, Shift alone selects digit symbols
   always_comb begin
      ascii = '0;
      hit   = 1'b0;
      if (is_letter && !ext) begin
         hit = 1'b1;
         if (ctrl) begin
            ascii = upper & 8'h1F;
         end else if (shift ^ caps) begin
            ascii = upper;
         end else begin
            ascii = upper | 8'h20;
         end
      end else if (is_digit && !ext) begin
         hit   = 1'b1;
         ascii = shift ? dig_shift : dig_plain;
      end else if (is_ctl) begin
         hit   = 1'b1;
         ascii = ctl_ch;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: modifier tracking, ASCII translation and a show-ahead character FIFO.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 3
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [REC_W-1:0]   rec_data,
   input  logic               rec_flag,
   input  logic               key_ready,
   output logic               key_valid,
   output logic [ASCII_W-1:0] key_ascii,
   output logic               shift_o,
   output logic               ctrl_o,
   output logic               caps_o,
   output logic               overflow,
   input  logic               overflow_clr,
   output logic [ADDR_W:0]    fifo_count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   scan_evt_t          evt;
   logic               unused_rec;
   logic               is_lshift;
   logic               is_rshift;
   logic               is_lctrl;
   logic               is_rctrl;
   logic               is_caps;
   logic               is_mod;
   logic [ASCII_W-1:0] xl_ascii;
   logic               xl_hit;

   logic               lshift_q;
   logic               rshift_q;
   logic               lctrl_q;
   logic               rctrl_q;
   logic               caps_q;
   logic               caps_held_q;

   logic               push_q;
   logic [ASCII_W-1:0] char_q;

   logic [ASCII_W-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]   count_q;
   logic               full;
   logic               pop;
   logic               wr_en;
   logic               drop;

   // Field extraction; remaining rec_data bits carry nothing for us
   assign evt        = '{ext: rec_data[EXT_BIT], brk: rec_data[BRK_BIT], code: rec_data[SCAN_W-1:0]};
   assign unused_rec = ^{rec_data[REC_W-1:EXT_BIT+1], rec_data[EXT_BIT-1:BRK_BIT+1]};

   // Modifier classification (E0 12 / E0 59 are fake shifts, not real ones)
   assign is_lshift = !evt.ext && (evt.code == SC_LSHIFT);
   assign is_rshift = !evt.ext && (evt.code == SC_RSHIFT);
   assign is_lctrl  = !evt.ext && (evt.code == SC_CTRL);
   assign is_rctrl  =  evt.ext && (evt.code == SC_CTRL);
   assign is_caps   = !evt.ext && (evt.code == SC_CAPS);
   assign is_mod    = is_lshift | is_rshift | is_lctrl | is_rctrl | is_caps;

   assign shift_o = lshift_q | rshift_q;
   assign ctrl_o  = lctrl_q | rctrl_q;
   assign caps_o  = caps_q;

   // Translation sees the modifier state from before this event
   ps2_scan2ascii u_scan2ascii (
      .code  (evt.code),
      .ext   (evt.ext),
      .shift (shift_o),
      .caps  (caps_q),
      .ctrl  (ctrl_o),
      .ascii (xl_ascii),
      .hit   (xl_hit)
   );

   // Modifier state; Caps toggles only on the first make so typematic repeats are harmless
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         lctrl_q     <= 1'b0;
         rctrl_q     <= 1'b0;
         caps_q      <= 1'b0;
         caps_held_q <= 1'b0;
      end else if (rec_flag) begin
         if (is_lshift) lshift_q <= !evt.brk;
         if (is_rshift) rshift_q <= !evt.brk;
         if (is_lctrl)  lctrl_q  <= !evt.brk;
         if (is_rctrl)  rctrl_q  <= !evt.brk;
         if (is_caps) begin
            if (evt.brk) begin
               caps_held_q <= 1'b0;
            end else begin
               if (!caps_held_q) caps_q <= !caps_q;
               caps_held_q <= 1'b1;
            end
         end
      end
   end

   // Event stage: one-cycle push of a translated make code
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         push_q <= 1'b0;
         char_q <= '0;
      end else begin
         push_q <= rec_flag && !evt.brk && !is_mod && xl_hit;
         if (rec_flag) char_q <= xl_ascii;
      end
   end

   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign key_valid = (count_q != '0);
   assign pop       = key_valid & key_ready;
   assign wr_en     = push_q & (!full | pop);
   assign drop      = push_q & full & !pop;

   assign key_ascii  = key_valid ? mem[rd_ptr] : '0;
   assign fifo_count = count_q;

   // Character storage
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_ptr] <= char_q;
      end
   end

   // Pointers, occupancy and sticky overflow (a drop beats a same-cycle clear)
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios plus randomized key traffic.
module tb_ps2_key_decoder;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 3;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic [15:0]       rec_data;
   logic              rec_flag;
   logic              key_ready;
   logic              key_valid;
   logic [7:0]        key_ascii;
   logic              shift_o;
   logic              ctrl_o;
   logic              caps_o;
   logic              overflow;
   logic              overflow_clr;
   logic [ADDR_W:0]   fifo_count;

   ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .rec_data     (rec_data),
      .rec_flag     (rec_flag),
      .key_ready    (key_ready),
      .key_valid    (key_valid),
      .key_ascii    (key_ascii),
      .shift_o      (shift_o),
      .ctrl_o       (ctrl_o),
      .caps_o       (caps_o),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .fifo_count   (fifo_count)
   );

   always #5 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;

   // Expected characters in delivery order
   byte unsigned sb[$];

   // Reference keyboard state
   bit m_lshift, m_rshift, m_lctrl, m_rctrl, m_caps, m_caps_held;

   byte unsigned letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
   byte unsigned digit_code [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                      8'h3E, 8'h46};
   string        shifted_digits   = ")!@#$%^&*(";

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Character a US keyboard produces for a make code, or 0 when nothing is typed
   function automatic bit model_char(input byte unsigned code, input bit ext, input bit shift,
                                     input bit caps, input bit ctrl, output byte unsigned ch);
      ch = 8'h00;
      if (ext) begin
         if (code == 8'h5A) begin ch = 8'h0D; return 1'b1; end
         if (code == 8'h4A) begin ch = 8'h2F; return 1'b1; end
         return 1'b0;
      end
      for (int i = 0; i < 26; i++) begin
         if (letter_code[i] == code) begin
            if (ctrl)              ch = 8'(i + 1);
            else if (shift ^ caps) ch = 8'(8'h41 + i);
            else                   ch = 8'(8'h61 + i);
            return 1'b1;
         end
      end
      for (int i = 0; i < 10; i++) begin
         if (digit_code[i] == code) begin
            ch = shift ? shifted_digits[i] : 8'(8'h30 + i);
            return 1'b1;
         end
      end
      case (code)
         8'h29: ch = 8'h20;
         8'h5A: ch = 8'h0D;
         8'h66: ch = 8'h08;
         8'h76: ch = 8'h1B;
         8'h0D: ch = 8'h09;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Issue one receiver event; 'accept' is 0 when the bench knows the FIFO will drop it
   task automatic send(input logic [15:0] d, input bit accept);
      bit           ext  = d[12];
      bit           brk  = d[8];
      byte unsigned code = d[7:0];
      byte unsigned ch;
      if (!brk && model_char(code, ext, m_lshift | m_rshift, m_caps, m_lctrl | m_rctrl, ch) && accept)
         sb.push_back(ch);
      if (!ext && code == 8'h12) m_lshift = !brk;
      if (!ext && code == 8'h59) m_rshift = !brk;
      if (code == 8'h14) begin
         if (ext) m_rctrl = !brk;
         else     m_lctrl = !brk;
      end
      if (!ext && code == 8'h58) begin
         if (brk) m_caps_held = 1'b0;
         else begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1'b1;
         end
      end
      rec_data = d;
      rec_flag = 1'b1;
      idle(1);
      rec_flag = 1'b0;
      rec_data = 16'h0000;
      check("shift_o", int'(shift_o), int'(m_lshift | m_rshift));
      check("ctrl_o",  int'(ctrl_o),  int'(m_lctrl | m_rctrl));
      check("caps_o",  int'(caps_o),  int'(m_caps));
   endtask

   task automatic drain();
      key_ready = 1'b1;
      for (int i = 0; i < 300 && sb.size() != 0; i++) idle(1);
      idle(2);
      check("drain_left", sb.size(), 0);
      check("drain_count", int'(fifo_count), 0);
   endtask

   function automatic logic [15:0] rand_event();
      byte unsigned mods [4]  = '{8'h12, 8'h59, 8'h14, 8'h58};
      byte unsigned exts [4]  = '{8'h5A, 8'h4A, 8'h14, 8'h71};
      byte unsigned ctls [5]  = '{8'h29, 8'h5A, 8'h66, 8'h76, 8'h0D};
      byte unsigned junk [5]  = '{8'h4A, 8'h71, 8'h0E, 8'h7C, 8'h83};
      int           r    = int'($urandom_range(0, 99));
      bit           ext  = 1'b0;
      bit           brk  = ($urandom_range(0, 99) < 15);
      byte unsigned code;
      if (r < 45)      code = letter_code[$urandom_range(0, 25)];
      else if (r < 60) code = digit_code[$urandom_range(0, 9)];
      else if (r < 70) code = ctls[$urandom_range(0, 4)];
      else if (r < 85) begin
         code = mods[$urandom_range(0, 3)];
         brk  = ($urandom_range(0, 1) == 1);
         if (code == 8'h14) ext = ($urandom_range(0, 1) == 1);
      end else if (r < 92) begin
         code = exts[$urandom_range(0, 3)];
         ext  = 1'b1;
      end else code = junk[$urandom_range(0, 4)];
      return {3'b000, ext, 3'b000, brk, code};
   endfunction

   // Monitor: every accepted head character must be the next expected one
   always @(negedge sys_clk) begin
      if (sys_rst === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_char: got 0x%0h expected none at %0t", key_ascii, $time);
         end else begin
            check("char", int'(key_ascii), int'(sb.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      sys_rst      = 1'b1;
      rec_data     = 16'h0000;
      rec_flag     = 1'b0;
      key_ready    = 1'b0;
      overflow_clr = 1'b0;
      idle(2);
      check("rst_valid", int'(key_valid), 0);
      check("rst_ascii", int'(key_ascii), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_ovf",   int'(overflow), 0);
      check("rst_mods",  int'({shift_o, ctrl_o, caps_o}), 0);
      sys_rst = 1'b0;
      idle(1);

      // Two-cycle latency and single pop
      send(16'h001C, 1'b1);
      check("lat_e0_valid", int'(key_valid), 0);
      idle(1);
      check("lat_valid", int'(key_valid), 1);
      check("lat_ascii", int'(key_ascii), 8'h61);
      check("lat_count", int'(fifo_count), 1);
      key_ready = 1'b1;
      idle(1);
      key_ready = 1'b0;
      check("pop_valid", int'(key_valid), 0);
      check("pop_count", int'(fifo_count), 0);

      // Shift make/break
      key_ready = 1'b1;
      send(16'h0012, 1'b1);
      send(16'h001C, 1'b1);
      send(16'h0112, 1'b1);
      send(16'h001C, 1'b1);
      drain();

      // Caps Lock with typematic repeats, then Shift inverting case
      send(16'h0058, 1'b1);
      send(16'h0058, 1'b1);
      send(16'h0058, 1'b1);
      send(16'h0158, 1'b1);
      send(16'h0032, 1'b1);
      send(16'h0012, 1'b1);
      send(16'h0032, 1'b1);
      send(16'h0112, 1'b1);
      drain();

      // Right Ctrl letter, then an unmapped extended key
      send(16'h1014, 1'b1);
      send(16'h0021, 1'b1);
      send(16'h1114, 1'b1);
      send(16'h1071, 1'b1);
      drain();

      // Overflow: nine pushes into eight entries
      key_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(16'h001C, i < 8);
      idle(1);
      check("full_count", int'(fifo_count), 8);
      check("full_ovf",   int'(overflow), 1);
      send(16'h0032, 1'b1);
      key_ready = 1'b1;
      idle(1);
      key_ready = 1'b0;
      check("pushpop_count", int'(fifo_count), 8);
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check("ovf_clr", int'(overflow), 0);
      send(16'h001C, 1'b0);
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check("ovf_set_wins", int'(overflow), 1);
      overflow_clr = 1'b1;
      idle(1);
      overflow_clr = 1'b0;
      check("ovf_clr2", int'(overflow), 0);
      drain();

      // Random traffic with a random consumer
      for (int n = 0; n < 400; n++) begin
         key_ready = ($urandom_range(0, 1) == 1);
         if (sb.size() < DEPTH) begin
            send(rand_event(), 1'b1);
            if ($urandom_range(0, 3) == 0) idle(1);
         end else begin
            idle(1);
         end
      end
      drain();

      // Asynchronous reset with queued characters and modifiers held
      key_ready = 1'b0;
      send(16'h0158, 1'b1);
      send(16'h0058, 1'b1);
      if (!m_caps) begin
         send(16'h0158, 1'b1);
         send(16'h0058, 1'b1);
      end
      send(16'h0012, 1'b1);
      send(16'h001C, 1'b1);
      send(16'h0021, 1'b1);
      send(16'h0023, 1'b1);
      idle(1);
      check("pre_rst_count", int'(fifo_count), 3);
      #3;
      sys_rst = 1'b1;
      #1;
      check("arst_valid", int'(key_valid), 0);
      check("arst_shift", int'(shift_o), 0);
      check("arst_caps",  int'(caps_o), 0);
      check("arst_count", int'(fifo_count), 0);
      sb.delete();
      {m_lshift, m_rshift, m_lctrl, m_rctrl, m_caps, m_caps_held} = '0;
      idle(1);
      sys_rst = 1'b0;
      idle(1);
      key_ready = 1'b1;
      send(16'h001C, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
